// File: rtl/matmul_pkg.sv
// Shared types and helpers for the N x N matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

  function automatic int res_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  // Row-major flat index of element [r][c] in an n x n matrix.
  function automatic int rm_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// W x W multiply into an RW-bit accumulator; MATMUL_SIGNED_EN selects two's-complement operands.
module matmul_mac #(
  parameter int W  = 8,
  parameter int RW = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [RW-1:0] acc
);

  logic [2*W-1:0] prod;
  logic [RW-1:0]  prod_x;

`ifdef MATMUL_SIGNED_EN
  assign prod   = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  assign prod_x = {{(RW-2*W){prod[2*W-1]}}, prod};
`else
  assign prod   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign prod_x = {{(RW-2*W){1'b0}}, prod};
`endif

  // clr starts a fresh dot product with this cycle's term, so the finished
  // sum stays readable for one cycle while the next element begins.
  always_ff @(posedge clk) begin
    if (reset)    acc <= '0;
    else if (en)  acc <= clr ? prod_x : acc + prod_x;
  end

endmodule

// File: rtl/matmul_nxn.sv
// N x N matrix multiplier: element-serial load, one sequential MAC, registered readout.
// Build option MATMUL_SIGNED_EN switches operands and result to two's-complement.
module matmul_nxn
  import matmul_pkg::*;
#(
  parameter int  N  = 2,
  parameter int  W  = 8,
  localparam int RW = res_width(N, W),
  localparam int AW = $clog2(2*N*N),
  localparam int OW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_sel,
  input  logic [W-1:0]  load_val,
  input  logic          execute,
  input  logic [OW-1:0] out_sel,
  output logic [RW-1:0] result,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] io_oeb
);

  localparam int NN = N * N;
  localparam int CW = $clog2(N);

  logic [NN-1:0][W-1:0]  a_mem, b_mem;
  logic [NN-1:0][RW-1:0] c_mem;
  state_t                state, state_n;
  logic [CW-1:0]         i_q, j_q, k_q;
  logic                  exec_q, exec_rise, last_mac, k_last;
  logic                  wr_vld;
  logic [OW-1:0]         wr_idx, a_idx, b_idx, ld_idx;
  logic                  ld_ok, ld_is_a;
  logic [RW-1:0]         mac_acc, rd_val;

  assign exec_rise = execute & ~exec_q;
  assign k_last    = (k_q == CW'(N-1));
  assign last_mac  = k_last && (j_q == CW'(N-1)) && (i_q == CW'(N-1));
  assign busy      = (state == COMPUTE);
  assign io_oeb    = '0;

  assign a_idx   = OW'(rm_idx(int'(i_q), int'(k_q), N));
  assign b_idx   = OW'(rm_idx(int'(k_q), int'(j_q), N));
  assign ld_ok   = (int'(load_sel) < 2*NN);
  assign ld_is_a = (int'(load_sel) < NN);
  assign ld_idx  = ld_is_a ? OW'(int'(load_sel)) : OW'(int'(load_sel) - NN);
  assign rd_val  = (int'(out_sel) < NN) ? c_mem[out_sel] : '0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (exec_rise) state_n = COMPUTE;
      COMPUTE: if (last_mac)  state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  matmul_mac #(.W(W), .RW(RW)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (k_q == '0),
    .en    (busy),
    .a     (a_mem[a_idx]),
    .b     (b_mem[b_idx]),
    .acc   (mac_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_mem  <= '0;
      b_mem  <= '0;
      c_mem  <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      exec_q <= 1'b0;
      wr_vld <= 1'b0;
      wr_idx <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_n;
      exec_q <= execute;
      // The sum completed at k==N-1 lands in C one cycle later; the last one during FINISH.
      wr_vld <= busy && k_last;
      wr_idx <= OW'(rm_idx(int'(i_q), int'(j_q), N));
      if (wr_vld) c_mem[wr_idx] <= mac_acc;
      case (state)
        IDLE: begin
          if (load_en && ld_ok) begin
            if (ld_is_a) a_mem[ld_idx] <= load_val;
            else         b_mem[ld_idx] <= load_val;
            done <= 1'b0;
          end
          if (exec_rise) begin
            c_mem <= '0;
            done  <= 1'b0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
          end
        end
        COMPUTE: begin
          k_q <= k_last ? '0 : k_q + CW'(1);
          if (k_last) begin
            j_q <= (j_q == CW'(N-1)) ? '0 : j_q + CW'(1);
            if (j_q == CW'(N-1)) i_q <= i_q + CW'(1);
          end
        end
        FINISH:  done <= 1'b1;
        default: ;
      endcase
      result <= (state_n == COMPUTE) ? '0 : rd_val;
    end
  end

endmodule

// File: tb/tb_matmul_nxn.sv
// Self-checking bench for matmul_nxn at N=3: directed corners plus randomized traffic vs a behavioural model.
module tb_matmul_nxn;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int NN = N * N;
  localparam int RW = 2*W + $clog2(N);
  localparam int AW = $clog2(2*NN);
  localparam int OW = $clog2(NN);
`ifdef MATMUL_SIGNED_EN
  localparam int MAXC = 3;
`else
  localparam int MAXC = 195075;
`endif

  logic          clk = 1'b0, reset = 1'b1, load_en = 1'b0, execute = 1'b0;
  logic [AW-1:0] load_sel = '0;
  logic [W-1:0]  load_val = '0;
  logic [OW-1:0] out_sel = '0;
  logic [RW-1:0] result, io_oeb;
  logic          busy, done;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  matmul_nxn #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel), .load_val(load_val),
    .execute(execute), .out_sel(out_sel), .result(result), .busy(busy), .done(done), .io_oeb(io_oeb)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Behavioural model: matrices as arrays, a run as a countdown of remaining cycles.
  logic [W-1:0]  mA [NN] = '{default: '0};
  logic [W-1:0]  mB [NN] = '{default: '0};
  logic [RW-1:0] mC [NN] = '{default: '0};
  int            rem = 0;
  bit            mdone = 1'b0, mexq = 1'b0;
  bit            e_busy = 1'b0, e_done = 1'b0, e_chk = 1'b0;
  logic [RW-1:0] e_res = '0;

  function automatic longint opv(input logic [W-1:0] x);
`ifdef MATMUL_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  function automatic logic [RW-1:0] dotp(input int i, input int j);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++) s += opv(mA[i*N+k]) * opv(mB[k*N+j]);
    return RW'(s);
  endfunction

  always @(posedge clk) begin : model
    int            rb;
    logic [RW-1:0] rd;
    rb = rem;
    rd = (int'(out_sel) < NN) ? mC[out_sel] : '0;
    if (reset) begin
      for (int q = 0; q < NN; q++) begin mA[q] = '0; mB[q] = '0; mC[q] = '0; end
      rem = 0; mdone = 1'b0; mexq = 1'b0; e_res = '0; e_chk = 1'b1;
    end else begin
      if (rem == 0) begin
        if (load_en && int'(load_sel) < 2*NN) begin
          if (int'(load_sel) < NN) mA[load_sel] = load_val;
          else                     mB[int'(load_sel) - NN] = load_val;
          mdone = 1'b0;
        end
        if (execute && !mexq) begin
          rem = N*N*N + 1;
          for (int q = 0; q < NN; q++) mC[q] = '0;
          mdone = 1'b0;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mC[i*N+j] = dotp(i, j);
          mdone = 1'b1;
        end
      end
      mexq  = execute;
      e_chk = (rem > 1) || (rb == 0);
      e_res = (rem > 1) ? '0 : rd;
    end
    e_busy = (rem > 1);
    e_done = mdone;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("io_oeb", io_oeb, 0);
      if (e_chk) chk("result", result, e_res);
    end
  end

  task automatic load(input int s, input int v);
    load_en = 1'b1; load_sel = AW'(s); load_val = W'(v);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_mats(input int av[NN], input int bv[NN]);
    for (int q = 0; q < NN; q++) load(q, av[q]);
    for (int q = 0; q < NN; q++) load(NN + q, bv[q]);
  endtask

  task automatic wait_done(output int bc);
    int n;
    n = 0; bc = 0;
    while (!done && n < 200) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    chk("run_done", done, 1);
  endtask

  task automatic run(output int bc);
    execute = 1'b1;
    @(negedge clk);
    execute = 1'b0;
    wait_done(bc);
  endtask

  task automatic read(input int s, input int exp);
    out_sel = OW'(s);
    @(negedge clk);
    chk("rd_result", result, exp);
    if (s < NN) chk("model_c", mC[s], exp);
  endtask

  int av[NN], bv[NN], allmax[NN];
  int bc, runs;
  bit prev;

  initial begin
    av = '{1, 2, 0, 3, 4, 0, 0, 0, 0};
    bv = '{5, 6, 0, 7, 8, 0, 0, 0, 0};
    allmax = '{default: 255};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);

    // Basic product, embedded 2x2 in the top-left corner.
    load_mats(av, bv);
    run(bc);
    chk("busy_cycles", bc, N*N*N);
    read(0, 19); read(1, 22); read(3, 43); read(4, 50); read(2, 0); read(8, 0);

    // A load after completion clears done but keeps C.
    chk("done_set", done, 1);
    load(5, 9);
    chk("done_clr", done, 0);
    read(4, 50);

    // All-max operands; a load during COMPUTE must be ignored.
    load_mats(allmax, allmax);
    execute = 1'b1; @(negedge clk); execute = 1'b0;
    repeat (3) @(negedge clk);
    load(0, 0);
    wait_done(bc);
    read(0, MAXC); read(8, MAXC); read(9, 0); read(15, 0);

    // Out-of-range load address is ignored and does not clear done.
    load(20, 1);
    chk("oor_done", done, 1);
    run(bc);
    read(4, MAXC);

    // Reset on the third busy cycle aborts the run.
    execute = 1'b1; @(negedge clk); execute = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    read(0, 0); read(4, 0);
    load_mats(av, bv);
    run(bc);
    read(1, 22); read(3, 43);

    // execute held high gives exactly one run.
    execute = 1'b1; runs = 0; prev = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy && !prev) runs++;
      prev = busy;
    end
    execute = 1'b0;
    chk("held_runs", runs, 1);

`ifdef MATMUL_SIGNED_EN
    av = '{255, 2, 0, 3, 252, 0, 0, 0, 0};
    bv = '{5, 250, 0, 7, 8, 0, 0, 0, 0};
    load_mats(av, bv);
    run(bc);
    read(0, 9); read(1, 22); read(3, (1 << RW) - 13); read(4, (1 << RW) - 50);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 2500; c++) begin
      reset    = ($urandom % 400 == 0);
      load_en  = ($urandom % 3 == 0);
      load_sel = AW'($urandom_range(0, 31));
      load_val = W'($urandom);
      execute  = ($urandom % 12 == 0);
      out_sel  = OW'($urandom_range(0, 15));
      @(negedge clk);
    end
    reset = 1'b0; load_en = 1'b0; execute = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
